// File: rtl/memory_utils_pkg.sv
// Shared PDP-8 word type, operate-group bit positions and the
// micro-op executor FSM state type.
package memory_utils_pkg;

    localparam int WORD_BITS = 12;

    typedef logic [WORD_BITS-1:0] word;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE,
        ST_HALT
    } micro_exec_state_t;

    localparam logic [2:0] OPR_OPCODE = 3'o7;

    localparam int G2_CLA_BIT = 7;
    localparam int G2_OSR_BIT = 2;
    localparam int G2_HLT_BIT = 1;
    localparam int G3_CLA_BIT = 7;
    localparam int MQA_BIT    = 6;
    localparam int MQL_BIT    = 4;

    function automatic logic is_operate(input word w);
        return w[WORD_BITS-1 -: 3] == OPR_OPCODE;
    endfunction

endpackage

// File: rtl/micro_op_executor_g3_mq_unit.sv
// Group 3 AC/MQ transfer: optional clear, then swap, OR-in or load
// of MQ as selected by MQA/MQL.
module micro_g3_mq_unit #(
    parameter int WORD_W = 12
) (
    input  logic [WORD_W-1:0] ac,
    input  logic [WORD_W-1:0] mq,
    input  logic              cla,
    input  logic              mqa,
    input  logic              mql,
    output logic [WORD_W-1:0] ac_next,
    output logic [WORD_W-1:0] mq_next
);

    logic [WORD_W-1:0] ac1;

    always_comb begin
        ac1     = cla ? '0 : ac;
        ac_next = ac1;
        mq_next = mq;
        unique case ({mqa, mql})
            2'b11: begin
                ac_next = mq;
                mq_next = ac1;
            end
            2'b10: ac_next = ac1 | mq;
            2'b01: begin
                ac_next = '0;
                mq_next = ac1;
            end
            default: ac_next = ac1;
        endcase
    end

endmodule

// File: rtl/micro_op_executor.sv
// Execute stage for PDP-8 operate instructions; owns AC, Link and MQ.
// MICRO_OSR_HLT_EN enables Group 2 OSR/HLT and the HALT state.
module micro_op_executor
    import memory_utils_pkg::*;
#(
    parameter int WORD_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] instr,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] switch_reg,
    input  logic              continue_run,
    input  logic              ac_wr_en,
    input  logic [WORD_W-1:0] ac_wr_data,
    input  logic              l_wr_data,
    output logic [8:0]        dec_i_reg,
    output logic [WORD_W-1:0] dec_ac,
    output logic              dec_l,
    input  logic [WORD_W-1:0] ac_micro,
    input  logic              l_micro,
    input  logic              skip,
    input  logic              micro_g1,
    input  logic              micro_g2,
    input  logic              micro_g3,
    output logic [WORD_W-1:0] ac_out,
    output logic              l_out,
    output logic [WORD_W-1:0] mq_out,
    output logic [WORD_W-1:0] pc_out,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              illegal
);

    micro_exec_state_t state, state_nx;

    logic [WORD_W-1:0] ac, ac_nx;
    logic [WORD_W-1:0] mq, mq_nx;
    logic [WORD_W-1:0] pc, pc_nx;
    logic [WORD_W-1:0] pc_q, pc_q_nx;
    logic [8:0]        ir, ir_nx;
    logic              l, l_nx;
    logic              illegal_q, illegal_nx;

    logic [WORD_W-1:0] g2_ac;
    logic              g2_halt;
    logic [WORD_W-1:0] g3_ac;
    logic [WORD_W-1:0] g3_mq;
    logic [WORD_W-1:0] pc_step;
    logic              opcode_ok;

    assign opcode_ok = instr[WORD_W-1 -: 3] == OPR_OPCODE;

    micro_g3_mq_unit #(
        .WORD_W(WORD_W)
    ) u_g3 (
        .ac      (ac),
        .mq      (mq),
        .cla     (ir[G3_CLA_BIT]),
        .mqa     (ir[MQA_BIT]),
        .mql     (ir[MQL_BIT]),
        .ac_next (g3_ac),
        .mq_next (g3_mq)
    );

    // CLA is applied after the decoder's skip test, which saw the old AC.
    always_comb begin
        g2_ac = ir[G2_CLA_BIT] ? '0 : ac;
`ifdef MICRO_OSR_HLT_EN
        if (ir[G2_OSR_BIT]) begin
            g2_ac = g2_ac | switch_reg;
        end
        g2_halt = ir[G2_HLT_BIT];
`else
        g2_halt = 1'b0;
`endif
    end

    assign pc_step = (skip && micro_g2) ? WORD_W'(2) : WORD_W'(1);

    always_comb begin
        state_nx   = state;
        ac_nx      = ac;
        l_nx       = l;
        mq_nx      = mq;
        ir_nx      = ir;
        pc_nx      = pc;
        pc_q_nx    = pc_q;
        illegal_nx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ac_wr_en) begin
                    ac_nx = ac_wr_data;
                    l_nx  = l_wr_data;
                end
                if (start) begin
                    if (opcode_ok) begin
                        ir_nx    = instr[8:0];
                        pc_nx    = pc_in;
                        state_nx = ST_EVAL;
                    end else begin
                        illegal_nx = 1'b1;
                    end
                end
            end
            ST_EVAL: begin
                pc_q_nx  = pc + pc_step;
                state_nx = ST_DONE;
                if (micro_g1) begin
                    ac_nx = ac_micro;
                    l_nx  = l_micro;
                end else if (micro_g2) begin
                    ac_nx = g2_ac;
                    if (g2_halt) begin
                        state_nx = ST_HALT;
                    end
                end else if (micro_g3) begin
                    ac_nx = g3_ac;
                    mq_nx = g3_mq;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
`ifdef MICRO_OSR_HLT_EN
            ST_HALT: begin
                if (continue_run) begin
                    state_nx = ST_DONE;
                end
            end
`else
            ST_HALT: state_nx = ST_IDLE;
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ac        <= '0;
            l         <= 1'b0;
            mq        <= '0;
            ir        <= '0;
            pc        <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            ac        <= ac_nx;
            l         <= l_nx;
            mq        <= mq_nx;
            ir        <= ir_nx;
            pc        <= pc_nx;
            pc_q      <= pc_q_nx;
            illegal_q <= illegal_nx;
        end
    end

    assign dec_i_reg = ir;
    assign dec_ac    = ac;
    assign dec_l     = l;
    assign ac_out    = ac;
    assign l_out     = l;
    assign mq_out    = mq;
    assign pc_out    = pc_q;
    assign busy      = (state == ST_EVAL) || (state == ST_DONE);
    assign done      = state == ST_DONE;
    assign illegal   = illegal_q;

`ifdef MICRO_OSR_HLT_EN
    assign halted = state == ST_HALT;
`else
    assign halted = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{switch_reg, continue_run};
`endif

endmodule
